serial_adder_ctrl: RTL

Bit-serial addition sequencer that time-multiplexes a single `full_adder` cell to add two WIDTH-bit operands over WIDTH cycles. It sits between a requester and the single-bit adder datapath, latching operands on a start pulse, driving one bit pair plus the registered carry per cycle, and assembling the sum LSB-first. It trades WIDTH cycles of latency for one adder cell in area-constrained paths.

---
 rtl/serial_adder_ctrl_pkg.sv | 11 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controllers:
// FSM state encodings and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell time-shared by the serial adder controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full_adder cell adds two WIDTH-bit
// operands LSB-first over WIDTH cycles, then pulses output_done.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             input_clk,
    input  logic             input_rst,
    input  logic             input_start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_cin,
    output logic             output_busy,
    output logic             output_done,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_shift_q, a_shift_d;
    logic [WIDTH-1:0] b_shift_q, b_shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic fa_sum, fa_cout;

    full_adder u_full_adder (
        .a    (a_shift_q[0]),
        .b    (b_shift_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_shift_d = a_shift_q;
        b_shift_d = b_shift_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cout_d    = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a start just like IDLE for back-to-back adds
                if (input_start) begin
                    a_shift_d = input_a;
                    b_shift_d = input_b;
                    carry_d   = input_cin;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d  = {fa_sum, result_q[WIDTH-1:1]};
                carry_d   = fa_cout;
                cout_d    = fa_cout;
                a_shift_d = a_shift_q >> 1;
                b_shift_d = b_shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_shift_q <= '0;
            b_shift_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_shift_q <= a_shift_d;
            b_shift_q <= b_shift_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
        end
    end

    assign output_busy = (state_q == ST_RUN);
    assign output_done = (state_q == ST_DONE);
    assign output_sum  = result_q;
    assign output_cout = cout_q;

endmodule
